// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execution unit: iterative radix-2 shift-add multiply
// and restoring divide on operand magnitudes, with a one-cycle fast path for
// divide-by-zero and signed overflow. Raises StallMD while an op is in flight.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        startE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [4:0]  RdE,
  output logic        StallMD,
  output logic        DoneE,
  output logic [31:0] MDResultE,
  output logic [4:0]  MDRdE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;     // mul: product; div: {remainder, quotient}
  logic [63:0] opa_q, opa_d;     // mul: shifting multiplicand; div: divisor in [31:0]
  logic [31:0] opb_q, opb_d;     // mul: shifting multiplier
  logic [31:0] res_q, res_d;
  logic [4:0]  mdrd_q, mdrd_d;
  logic        stall_c;

  // Operand decode for the op presented in EX
  logic        is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, fast;
  logic [31:0] mag_a, mag_b, fast_res;

  // Classify the incoming op and form magnitudes and fast-path results
  always_comb begin
    is_div   = funct3E[2];
    a_sgn    = is_div ? ~funct3E[0] : (funct3E == 3'd1 || funct3E == 3'd2);
    b_sgn    = is_div ? ~funct3E[0] : (funct3E == 3'd1);
    a_neg    = a_sgn & SrcAE[31];
    b_neg    = b_sgn & SrcBE[31];
    mag_a    = a_neg ? (~SrcAE + 32'd1) : SrcAE;
    mag_b    = b_neg ? (~SrcBE + 32'd1) : SrcBE;
    div_zero = is_div && (SrcBE == '0);
    div_ovf  = is_div && !funct3E[0] && (SrcAE == 32'h8000_0000) && (SrcBE == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = funct3E[1] ? SrcAE : '1;
    else          fast_res = funct3E[1] ? '0 : 32'h8000_0000;
  end

  // One iteration step of the latched op, plus the signed final result
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] acc_mul, acc_div, acc_iter, prod;
  logic [31:0] dsel, final_res;

  always_comb begin
    acc_mul  = acc_q + (opb_q[0] ? opa_q : '0);
    rem_sh   = acc_q[63:31];
    rem_ge   = rem_sh >= {1'b0, opa_q[31:0]};
    rem_sub  = rem_sh[31:0] - opa_q[31:0];
    acc_div  = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                      : {rem_sh[31:0], acc_q[30:0], 1'b0};
    acc_iter = op_q[2] ? acc_div : acc_mul;
    prod     = neg_q ? (~acc_iter + 64'd1) : acc_iter;
    dsel     = op_q[1] ? acc_iter[63:32] : acc_iter[31:0];
    if (op_q[2])              final_res = neg_q ? (~dsel + 32'd1) : dsel;
    else if (op_q[1:0] == '0) final_res = prod[31:0];
    else                      final_res = prod[63:32];
  end

  // Next-state, datapath update and stall request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    mdrd_d  = mdrd_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (startE) begin
          op_d  = funct3E;
          rd_d  = RdE;
          cnt_d = '0;
          neg_d = (funct3E[2] & funct3E[1]) ? a_neg : (a_neg ^ b_neg);
          if (fast) begin
            res_d   = fast_res;
            mdrd_d  = RdE;
            state_d = S_DONE;
          end else begin
            stall_c = 1'b1;
            state_d = S_RUN;
            if (is_div) begin
              acc_d = {32'd0, mag_a};
              opa_d = {32'd0, mag_b};
              opb_d = '0;
            end else begin
              acc_d = '0;
              opa_d = {32'd0, mag_a};
              opb_d = mag_b;
            end
          end
        end
      end
      S_RUN: begin
        stall_c = 1'b1;
        acc_d   = acc_iter;
        opa_d   = op_q[2] ? opa_q : {opa_q[62:0], 1'b0};
        opb_d   = {1'b0, opb_q[31:1]};
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          res_d   = final_res;
          mdrd_d  = rd_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a start in the same cycle
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
      mdrd_d  = mdrd_q;
      stall_c = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      mdrd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      mdrd_q  <= mdrd_d;
    end
  end

  // Stall is combinational from the EX op, so it is also held low during reset
  assign StallMD   = stall_c & reset;
  assign DoneE     = (state_q == S_DONE);
  assign MDResultE = res_q;
  assign MDRdE     = mdrd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk, reset, flush, startE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        StallMD, DoneE;
  logic [31:0] MDResultE;
  logic [4:0]  MDRdE;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .startE(startE),
    .funct3E(funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE),
    .StallMD(StallMD), .DoneE(DoneE), .MDResultE(MDResultE), .MDRdE(MDRdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = {{32{a[31] & (f3 == 3'd1 || f3 == 3'd2)}}, a};
    eb  = {{32{b[31] & (f3 == 3'd1)}}, b};
    p   = ea * eb;
    case (f3)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, scramble operands after acceptance, wait for DoneE and score it
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv, input bit fast,
                       input bit nowait, input string name);
    int stalls, cyc, done_at;
    logic [36:0] e;
    stalls = 0; cyc = 0; done_at = -1;
    exp_q.push_back({rd, expv});
    if (!nowait) @(negedge clk);
    startE = 1'b1; funct3E = f3; SrcAE = a; SrcBE = b; RdE = rd;
    while (cyc < 80 && done_at < 0) begin
      if (cyc > 0) begin
        @(negedge clk);
        SrcAE = $urandom; SrcBE = $urandom;
      end
      #1;
      if (StallMD === 1'b1) stalls++;
      if (DoneE === 1'b1) begin
        done_at = cyc;
        startE  = 1'b0;
        checks += 2;
        if (exp_q.size() == 0) begin
          errors += 2;
          $display("FAIL %s scoreboard empty at DoneE, got %h", name, MDResultE);
        end else begin
          e = exp_q.pop_front();
          if (MDResultE !== e[31:0]) begin
            errors++;
            $display("FAIL %s result got %h expected %h", name, MDResultE, e[31:0]);
          end
          if (MDRdE !== e[36:32]) begin
            errors++;
            $display("FAIL %s rd got %0d expected %0d", name, MDRdE, e[36:32]);
          end
        end
      end
      cyc++;
    end
    checks++;
    if (done_at < 0) begin
      errors++;
      startE = 1'b0;
      void'(exp_q.pop_front());
      $display("FAIL %s timeout got no DoneE expected DoneE within 80 cycles", name);
    end else if (done_at != (fast ? 1 : 33)) begin
      errors++;
      $display("FAIL %s done_cycle got %0d expected %0d", name, done_at, fast ? 1 : 33);
    end
    checks++;
    if (stalls != (fast ? 0 : 33)) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d expected %0d", name, stalls, fast ? 0 : 33);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; startE = 1'b0; funct3E = '0; SrcAE = '0; SrcBE = '0; RdE = '0;
    #3;
    checks++;
    if ({StallMD, DoneE, MDResultE, MDRdE} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b/%h/%0d expected all zero", StallMD, DoneE, MDResultE, MDRdE);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({StallMD, DoneE} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got %b%b expected 00", StallMD, DoneE);
    end
  endtask

  task automatic test_mul();
    do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 0, 0, "mul_7x-3");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0, 0, "mulhu_max");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 0, 0, "mulh_min");
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 32'hFFFF_FFFF, 0, 0, "mulhsu_-1x2");
  endtask

  task automatic test_div();
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'hFFFF_FFFA, 0, 0, "div_-20/3");
    do_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFE, 0, 0, "rem_-20/3");
    do_op(3'd5, 32'hFFFF_FFFF, 32'h10, 5'd7, 32'h0FFF_FFFF, 0, 0, "divu_max/16");
  endtask

  task automatic test_fast_path();
    do_op(3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, 0, "div_by_zero");
    do_op(3'd7, 32'h1234_5678, 32'd0, 5'd9, 32'h1234_5678, 1, 0, "remu_by_zero");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1, 0, "rem_overflow");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 0, "div_overflow");
  endtask

  task automatic test_flush();
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    @(negedge clk);
    startE = 1'b1; funct3E = 3'd0; SrcAE = 32'd5; SrcBE = 32'd6; RdE = 5'd12;
    repeat (11) @(negedge clk);
    prev_res = MDResultE; prev_rd = MDRdE;
    flush = 1'b1;
    #1;
    checks++;
    if (StallMD !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got %b expected 0", StallMD);
    end
    @(negedge clk);
    flush = 1'b0; startE = 1'b0;
    #1;
    checks++;
    if ({DoneE, StallMD, MDResultE, MDRdE} !== {2'b00, prev_res, prev_rd}) begin
      errors++;
      $display("FAIL flush_idle got done=%b stall=%b res=%h rd=%0d expected 0 0 %h %0d",
               DoneE, StallMD, MDResultE, MDRdE, prev_res, prev_rd);
    end
    do_op(3'd0, 32'd3, 32'd4, 5'd13, 32'h0000_000C, 0, 1, "mul_after_flush");
  endtask

  task automatic test_reset_mid_run();
    int bad;
    bad = 0;
    @(negedge clk);
    startE = 1'b1; funct3E = 3'd0; SrcAE = 32'd7; SrcBE = 32'd9; RdE = 5'd14;
    repeat (21) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({StallMD, DoneE, MDResultE, MDRdE} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run got %b/%b/%h/%0d expected all zero", StallMD, DoneE, MDResultE, MDRdE);
    end
    startE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (DoneE !== 1'b0 || StallMD !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_reset_release got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    do_op(3'd5, 32'd100, 32'd7, 5'd15, 32'd14, 0, 0, "divu_100/7");
    do_op(3'd7, 32'd100, 32'd7, 5'd16, 32'd2, 0, 0, "remu_100/7");
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          fast;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : $urandom;
      if (i % 5 == 1) a = -a;
      fast = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      do_op(f3, a, b, 5'(i + 17), ref_model(f3, a, b), fast, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and reset (active-low, asynchronous assert).
REQ-002 Ports SHALL be as listed below, clock and reset first.
- clk  in  1  pipeline clock
- reset  in  1  async active-low reset
- flush  in  1  sync abort of any in-flight operation
- startE  in  1  EX-stage instruction is an RV32M op (from ID/EX register)
- funct3E  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- SrcAE  in  32  forwarded operand rs1
- SrcBE  in  32  forwarded operand rs2
- RdE  in  5  destination register
- StallMD  out  1  freeze request to hazard unit (stalls IF, ID and ID/EX)
- DoneE  out  1  result valid this cycle
- MDResultE  out  32  result
- MDRdE  out  5  destination of the completed op

Function
REQ-003 States SHALL be IDLE, RUN, DONE; encoding is free.
REQ-004 IDLE with startE=1 and flush=0 SHALL latch the operands, funct3E and RdE, clear the 6-bit iteration counter, and go to RUN. Fast-path cases (REQ-010, REQ-011) SHALL go directly to DONE instead.
REQ-005 RUN SHALL perform one radix-2 iteration per cycle for exactly 32 cycles (counter 0..31), then go to DONE.
REQ-006 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; startE SHALL NOT be sampled in DONE.
REQ-007 StallMD SHALL equal (state==IDLE & startE & ~fast-path) | (state==RUN), and SHALL be 0 in DONE so the pipeline advances at the end of the DONE cycle.
REQ-008 DoneE SHALL be 1 only in DONE; MDResultE and MDRdE SHALL be registered and held stable from DONE until the next accepted start.
REQ-009 Normal-op latency SHALL be 33 cycles from the accept edge to DoneE=1, with StallMD high for 33 cycles. Fast-path latency SHALL be 1 cycle, with StallMD low throughout.
REQ-010 Divide by zero (SrcBE=0, funct3 4..7) SHALL be fast-path: DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcAE.
REQ-011 Signed overflow (DIV/REM, SrcAE=0x80000000, SrcBE=0xFFFFFFFF) SHALL be fast-path: DIV returns 0x80000000; REM returns 0.
REQ-012 Multiply SHALL use shift-add on operand magnitudes into a 64-bit accumulator, with the final two's-complement negation applied in DONE entry.
- A is signed for MULH and MULHSU.
- B is signed for MULH only.
- MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
REQ-013 Divide SHALL use restoring division on magnitudes.
- Quotient sign = sign(A) xor sign(B), for DIV only.
- Remainder sign = sign(A), for REM only.
- DIVU and REMU are unsigned.
REQ-014 Operand changes on SrcAE/SrcBE after acceptance SHALL NOT affect the result.
REQ-015 flush=1 in any state SHALL force IDLE on the next edge with no DoneE pulse, MDResultE/MDRdE unchanged, and StallMD=0 in that cycle. flush SHALL take priority over startE.
REQ-016 startE falling during RUN (without flush) SHALL NOT abort the operation.

Reset
REQ-017 While reset=0: state=IDLE, counter=0, StallMD=0, DoneE=0, MDResultE=0x00000000, MDRdE=0, all internal accumulators 0.
REQ-018 Reset asserted mid-RUN SHALL discard the operation immediately (asynchronously). After release the block SHALL idle until a new startE.

Verification
REQ-019 The bench SHALL cover the following directed scenarios.
- MUL: 7 x -3 (0x00000007, 0xFFFFFFFD) -> StallMD high 33 cycles, DoneE at cycle 33, MDResultE=0xFFFFFFEB.
- MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH: 0x80000000 x 0x80000000 -> 0x40000000. MULHSU: 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV: -20 / 3 -> 0xFFFFFFFA. REM: same operands -> 0xFFFFFFFE. DIVU: 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF.
- Fast path: DIV x/0 with x=5 -> DoneE next cycle, result 0xFFFFFFFF, StallMD never high. REM 0x80000000 / -1 -> 0.
- flush at RUN cycle 10 -> IDLE next cycle, no DoneE. A new MUL 3 x 4 issued immediately after -> 0x0000000C after 33 cycles.
- reset pulsed low at RUN cycle 20 -> all outputs 0 immediately. Back-to-back DIVU 100/7 then REMU 100/7 -> 14 and 2, second accepted the cycle after DONE.
